// File: rtl/ring_osc_freq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : ring_osc_freq_counter
//  Description : Digital frequency reading of the on-chip ring oscillator.
//                The asynchronous oscillator output is synchronized into the
//                clk domain and its rising edges are counted over a window of
//                gate_len clk cycles. The result is held on count until the
//                next completed window.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   system clock
//    rst_n     in   synchronous active-low reset
//    osc_in    in   ring-oscillator output, asynchronous to clk
//    start     in   measurement request, honoured only while idle
//    gate_len  in   window length in clk cycles, latched on accepted start
//    count     out  rising edges seen in the last completed window
//    done      out  one-cycle pulse when count/overflow are updated
//    busy      out  high from accepted start until done
//    overflow  out  last window saturated the edge counter
// ============================================================================
module ring_osc_freq_counter #(
  parameter int COUNT_W     = 16,
  parameter int GATE_W      = 16,
  parameter int SYNC_STAGES = 2   // must be 2 or more
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               osc_in,
  input  logic               start,
  input  logic [GATE_W-1:0]  gate_len,
  output logic [COUNT_W-1:0] count,
  output logic               done,
  output logic               busy,
  output logic               overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   prev;
  logic                   rise;

  logic [GATE_W-1:0]  timer, timer_nxt;
  logic [COUNT_W-1:0] edge_cnt, edge_cnt_nxt;
  logic               sat, sat_nxt;

  // --------------------------------------------------------------------------
  // Input synchronizer and rising-edge detector
  // --------------------------------------------------------------------------
  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
      // prev tracks sync_out every cycle, so in ARM it already holds the
      // level present at window open and no spurious edge is seen there.
      prev   <= sync_out;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state, timer and edge-counter logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    edge_cnt_nxt = edge_cnt;
    sat_nxt      = sat;

    case (state)
      IDLE: begin
        if (start) begin
          timer_nxt = gate_len;
          state_nxt = ARM;
        end
      end

      ARM: begin
        edge_cnt_nxt = '0;
        sat_nxt      = 1'b0;
        if (timer == '0) begin
          state_nxt = DONE;
        end else begin
          state_nxt = MEASURE;
        end
      end

      MEASURE: begin
        timer_nxt = timer - GATE_W'(1);
        if (rise) begin
          // Saturate rather than wrap; the flag marks that an edge was lost.
          if (&edge_cnt) begin
            sat_nxt = 1'b1;
          end else begin
            edge_cnt_nxt = edge_cnt + COUNT_W'(1);
          end
        end
        if (timer == GATE_W'(1)) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      edge_cnt <= edge_cnt_nxt;
      sat      <= sat_nxt;
      // Outputs are decoded from the next state so they line up with the
      // state register. The result is taken from the next counter value so
      // an edge in the final MEASURE cycle is included.
      done     <= (state_nxt == DONE);
      busy     <= (state_nxt != IDLE);
      if (state_nxt == DONE) begin
        count    <= edge_cnt_nxt;
        overflow <= sat_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ring_osc_freq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ring_osc_freq_counter
//  Description : Directed self-checking bench for ring_osc_freq_counter.
//                Drives a bench-generated square wave on osc_in and checks
//                latency, busy length, done pulses, count and overflow.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ring_osc_freq_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        osc = 1'b0;
  logic        start = 1'b0;
  logic [15:0] gate_len = '0;
  logic [15:0] count;
  logic        done, busy, overflow;

  logic        start4 = 1'b0;
  logic [15:0] gate4 = '0;
  logic [3:0]  count4;
  logic        done4, busy4, overflow4;

  int tests_run = 0;
  int tests_failed = 0;

  ring_osc_freq_counter #(.COUNT_W(16), .GATE_W(16), .SYNC_STAGES(2)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .osc_in   (osc),
    .start    (start),
    .gate_len (gate_len),
    .count    (count),
    .done     (done),
    .busy     (busy),
    .overflow (overflow)
  );

  ring_osc_freq_counter #(.COUNT_W(4), .GATE_W(16), .SYNC_STAGES(2)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .osc_in   (osc),
    .start    (start4),
    .gate_len (gate4),
    .count    (count4),
    .done     (done4),
    .busy     (busy4),
    .overflow (overflow4)
  );

  always #5 clk = ~clk;

  // Oscillator model: period in clk cycles (0 = hold at osc_hold level),
  // changing a few ns after the clock edge so it is not edge-aligned.
  int   tick = 0;
  int   per = 2;
  int   phase = 0;
  logic osc_hold = 1'b0;

  always @(posedge clk) tick <= tick + 1;

  always @(posedge clk) begin
    #3;
    if (per > 0) osc = (((tick + phase) % per) < (per / 2));
    else         osc = osc_hold;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One measurement on the 16-bit instance. Cycle n=1 is the cycle after the
  // one in which start was high. Optionally pokes start/gate_len mid-window.
  task automatic measure16(input int g, input int poke_at,
                           output int lat, output int busy_cyc, output int pulses);
    lat = -1; busy_cyc = 0; pulses = 0;
    @(posedge clk); #1 start = 1'b1; gate_len = g[15:0];
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= g + 8; n++) begin
      if (poke_at > 0 && n == poke_at) begin
        start = 1'b1; gate_len = 16'd5;
      end else if (poke_at > 0 && n == poke_at + 1) begin
        start = 1'b0;
      end
      if (busy) busy_cyc++;
      if (done) begin
        pulses++;
        if (lat < 0) lat = n;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run16(input string tag, input int g, input int poke_at,
                       input int exp_cnt, input int exp_ovf);
    int lat, bc, pl;
    measure16(g, poke_at, lat, bc, pl);
    check({tag, ".latency"}, lat, g + 2);
    check({tag, ".busy_cycles"}, bc, g + 2);
    check({tag, ".done_pulses"}, pl, 1);
    check({tag, ".count"}, {16'd0, count}, exp_cnt);
    check({tag, ".overflow"}, {31'd0, overflow}, exp_ovf);
  endtask

  task automatic run4(input string tag, input int exp_cnt, input int exp_ovf);
    int pl;
    pl = 0;
    @(posedge clk); #1 start4 = 1'b1; gate4 = 16'd256;
    @(posedge clk); #1 start4 = 1'b0;
    for (int n = 1; n <= 270; n++) begin
      if (done4) pl++;
      @(posedge clk); #1;
    end
    check({tag, ".done_pulses"}, pl, 1);
    check({tag, ".count"}, {28'd0, count4}, exp_cnt);
    check({tag, ".overflow"}, {31'd0, overflow4}, exp_ovf);
  endtask

  initial begin
    int pl, bc, last_done, first_done;
    int phases[3] = '{1, 3, 6};

    // Reset with osc toggling
    rst_n = 1'b0; per = 2;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset.count", {16'd0, count}, 0);
    check("reset.done", {31'd0, done}, 0);
    check("reset.busy", {31'd0, busy}, 0);
    check("reset.overflow", {31'd0, overflow}, 0);
    pl = 0;
    for (int n = 0; n < 10; n++) begin
      if (done || busy) pl++;
      @(posedge clk); #1;
    end
    check("reset.idle_no_activity", pl, 0);

    // Period 8, window 64 -> 8 edges at several phases
    per = 8; phase = 0;
    repeat (4) @(posedge clk); #1;
    run16("p8_phase0", 64, 0, 8, 0);
    for (int i = 0; i < 3; i++) begin
      phase = phases[i];
      repeat (4) @(posedge clk); #1;
      run16($sformatf("p8_phase%0d", phases[i]), 64, 0, 8, 0);
    end

    // Oscillator stopped high
    per = 0; osc_hold = 1'b1;
    repeat (4) @(posedge clk); #1;
    run16("osc_stuck1", 100, 0, 0, 0);

    // start and gate_len poked mid-window: ignored
    per = 8; phase = 2;
    repeat (4) @(posedge clk); #1;
    run16("poke_midwin", 64, 20, 8, 0);

    // Reset mid-window aborts the measurement
    @(posedge clk); #1 start = 1'b1; gate_len = 16'd64;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    check("abort.busy", {31'd0, busy}, 0);
    check("abort.count", {16'd0, count}, 0);
    pl = 0; bc = 0;
    for (int n = 0; n < 80; n++) begin
      if (done) pl++;
      if (busy) bc++;
      @(posedge clk); #1;
    end
    check("abort.done_pulses", pl, 0);
    check("abort.busy_cycles", bc, 0);

    // Zero-length window
    run16("gate0", 0, 0, 0, 0);

    // Back-to-back with start held: done every gate_len+3 cycles
    gate_len = 16'd2;
    @(posedge clk); #1 start = 1'b1;
    pl = 0; first_done = -1; last_done = -1; bc = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        pl++;
        if (first_done < 0) first_done = n;
        else if (n - last_done != 5) bc++;
        last_done = n;
      end
    end
    start = 1'b0;
    check("b2b.first_latency", first_done, 4);
    check("b2b.bad_intervals", bc, 0);
    check("b2b.done_pulses", pl, 8);
    repeat (10) @(posedge clk); #1;

    // Narrow counter: saturation, then a clean result
    per = 4; phase = 0;
    repeat (4) @(posedge clk); #1;
    run4("w4_sat", 15, 1);
    per = 64;
    repeat (4) @(posedge clk); #1;
    run4("w4_p64", 4, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
